parity_frame_checker: RTL

Serial parity checker, parametrised successor of the 5-input combinational parity checker. It receives a frame of DATA_W data bits followed by one parity bit on a serial valid-qualified input. Even or odd parity is selectable per frame. The block reports the captured data, a parity error flag and a one-cycle frame-done pulse, and keeps a saturating error counter. It sits between a serial link front end and downstream frame consumers.

---
 rtl/parity_frame_checker.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/parity_frame_checker.sv
// Serial parity frame checker.
// Receives DATA_W data bits (LSB first) followed by one parity bit on a
// valid-qualified serial input. Even or odd parity is latched per frame at
// start. Reports captured data, a parity error flag, a one-cycle frame_valid
// pulse and a saturating error counter.
//
// Handshake: bit_in is consumed on every rising edge where bit_valid=1 while
// the FSM is in DATA or PARITY; there is no back-pressure, and bit_valid=0
// cycles leave all frame state untouched.
module parity_frame_checker #(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              odd_mode,
  input  logic              bit_in,
  input  logic              bit_valid,
  input  logic              abort,
  input  logic              clr_cnt,
  output logic              busy,
  output logic [DATA_W-1:0] data_out,
  output logic              frame_valid,
  output logic              parity_err,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [1:0]        dbg_state
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic                acc_q, acc_d;
  logic                mode_q, mode_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                perr_q, perr_d;
  logic                fv_q, fv_d;
  logic [CNT_W-1:0]    errcnt_q, errcnt_d;
  logic                frame_err;

  // State and datapath registers; async reset clears everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      shreg_q  <= '0;
      acc_q    <= 1'b0;
      mode_q   <= 1'b0;
      data_q   <= '0;
      perr_q   <= 1'b0;
      fv_q     <= 1'b0;
      errcnt_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      shreg_q  <= shreg_d;
      acc_q    <= acc_d;
      mode_q   <= mode_d;
      data_q   <= data_d;
      perr_q   <= perr_d;
      fv_q     <= fv_d;
      errcnt_q <= errcnt_d;
    end
  end

  // Next-state and datapath update: frame sequencing, bit capture, parity check.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    shreg_d   = shreg_q;
    acc_d     = acc_q;
    mode_d    = mode_q;
    data_d    = data_q;
    perr_d    = perr_q;
    fv_d      = 1'b0;
    errcnt_d  = errcnt_q;
    frame_err = acc_q ^ bit_in ^ mode_q;

    case (state_q)
      S_IDLE: begin
        // abort in IDLE suppresses a simultaneous start
        if (start && !abort) begin
          state_d = S_DATA;
          idx_d   = '0;
          shreg_d = '0;
          acc_d   = 1'b0;
          mode_d  = odd_mode;
        end
      end
      S_DATA: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (bit_valid) begin
          shreg_d[idx_q] = bit_in;
          acc_d          = acc_q ^ bit_in;
          if (idx_q == LAST_IDX) begin
            state_d = S_PARITY;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (bit_valid) begin
          state_d = S_DONE;
          data_d  = shreg_q;
          perr_d  = frame_err;
          fv_d    = 1'b1;
          if (frame_err && (errcnt_q != CNT_MAX)) begin
            errcnt_d = errcnt_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // clear wins over a same-cycle increment
    if (clr_cnt) begin
      errcnt_d = '0;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign data_out    = data_q;
  assign frame_valid = fv_q;
  assign parity_err  = perr_q;
  assign err_cnt     = errcnt_q;
  assign dbg_state   = state_q;

endmodule
